// File: rtl/fir_arith_pkg.sv
// Shared types and constant helpers for the FIR datapath prefix adder/subtractor family.
// Provides the (g,p) pair used by every Brent-Kung prefix cell.
package fir_arith_pkg;

    typedef struct packed {
        logic g;
        logic p;
    } pg_t;

    function automatic int clog2(input int n);
        int r;
        r = 32'sd0;
        for (int i = 32'sd0; i < 32'sd31; i++) begin
            if ((32'sd1 << i) < n) begin
                r = i + 32'sd1;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    // Most positive two's-complement value of a w-bit word, zero-extended to 64 bits.
    function automatic logic [63:0] signed_max(input int w);
        return (64'd1 << (w - 32'sd1)) - 64'd1;
    endfunction

    function automatic logic [63:0] signed_min(input int w);
        return 64'd1 << (w - 32'sd1);
    endfunction

endpackage

// File: rtl/bk_pg_cell.sv
// One Brent-Kung prefix operator: (g,p) o (g',p') = (g | p&g', p&p').
// i_hi is the more significant span, i_lo the span directly below it.
module bk_pg_cell
    import fir_arith_pkg::*;
(
    input  pg_t i_hi,
    input  pg_t i_lo,
    output pg_t o_pg
);

    assign o_pg.g = i_hi.g | (i_hi.p & i_lo.g);
    assign o_pg.p = i_hi.p & i_lo.p;

endmodule

// File: rtl/bk_sub_pipe.sv
// Two-stage pipelined Brent-Kung subtractor (diff = a - b - borrow_in) with valid/ready flow control.
// Define SUB_SAT_EN to clamp overflowing results to the signed extreme instead of wrapping.
module bk_sub_pipe
    import fir_arith_pkg::*;
#(
    parameter int WIDTH = 32'sd16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             ovf
);

    localparam int DEPTH = clog2(WIDTH);

    logic             w_adv1;
    logic             w_adv2;
    logic [WIDTH-1:0] w_p_raw;

    pg_t  [WIDTH-1:0] r_up;
    logic [WIDTH-1:0] r_p;
    logic             r_cin;
    logic             r_a_msb;
    logic             r_b_msb;
    logic             r_valid1;

    pg_t  [WIDTH-1:0] w_pre;
    logic [WIDTH-1:0] w_c;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic             w_ovf;

    logic             r_valid2;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;
    logic             r_ovf;

    assign w_adv2   = ~r_valid2 | out_ready;
    assign w_adv1   = ~r_valid1 | w_adv2;
    assign in_ready = w_adv1;

    assign out_valid  = r_valid2;
    assign diff       = r_diff;
    assign borrow_out = r_borrow;
    assign ovf        = r_ovf;

    // Subtraction runs as a + ~b + cin, so the bit terms use the inverted subtrahend.
    assign w_p_raw = ~(a ^ b);

    for (genvar l = 0; l <= DEPTH; l++) begin : g_up
        pg_t [WIDTH-1:0] w_pg;
        for (genvar i = 0; i < WIDTH; i++) begin : g_node
            if (l == 0) begin : g_leaf
                assign w_pg[i].g = a[i] & ~b[i];
                assign w_pg[i].p = w_p_raw[i];
            end else if (((i + 32'sd1) % (32'sd1 << l)) == 32'sd0) begin : g_cell
                bk_pg_cell u_cell (
                    .i_hi (g_up[l-1].w_pg[i]),
                    .i_lo (g_up[l-1].w_pg[i - (32'sd1 << (l - 1))]),
                    .o_pg (w_pg[i])
                );
            end else begin : g_pass
                assign w_pg[i] = g_up[l-1].w_pg[i];
            end
        end
    end

    // Stage-1 operand registers; loaded only on an accepted beat so idle X never enters.
    always_ff @(posedge clk) begin
        if (w_adv1 && in_valid) begin
            r_up    <= g_up[DEPTH].w_pg;
            r_p     <= w_p_raw;
            r_cin   <= ~borrow_in;
            r_a_msb <= a[WIDTH-1];
            r_b_msb <= b[WIDTH-1];
        end
    end

    // Down-sweep: each level fills the prefixes sitting halfway between already-complete ones.
    for (genvar l = DEPTH; l >= 1; l--) begin : g_dn
        pg_t [WIDTH-1:0] w_pg;
        if (l == DEPTH) begin : g_base
            assign w_pg = r_up;
        end else begin : g_lvl
            for (genvar i = 0; i < WIDTH; i++) begin : g_node
                if ((i >= (32'sd1 << l)) &&
                    (((i + 32'sd1) % (32'sd1 << l)) == (32'sd1 << (l - 1)))) begin : g_cell
                    bk_pg_cell u_cell (
                        .i_hi (g_dn[l+1].w_pg[i]),
                        .i_lo (g_dn[l+1].w_pg[i - (32'sd1 << (l - 1))]),
                        .o_pg (w_pg[i])
                    );
                end else begin : g_pass
                    assign w_pg[i] = g_dn[l+1].w_pg[i];
                end
            end
        end
    end

    assign w_pre = g_dn[1].w_pg;

    // With full prefixes in hand, the carry ripple from cin collapses to one term per bit.
    for (genvar i = 0; i < WIDTH; i++) begin : g_carry
        assign w_c[i] = w_pre[i].g | (w_pre[i].p & r_cin);
        if (i == 0) begin : g_lsb
            assign w_sum[i] = r_p[i] ^ r_cin;
        end else begin : g_upper
            assign w_sum[i] = r_p[i] ^ w_c[i-1];
        end
    end

`ifdef SUB_SAT_EN
    localparam logic [63:0]      L_SMAX64 = signed_max(WIDTH);
    localparam logic [63:0]      L_SMIN64 = signed_min(WIDTH);
    localparam logic [WIDTH-1:0] L_SMAX   = L_SMAX64[WIDTH-1:0];
    localparam logic [WIDTH-1:0] L_SMIN   = L_SMIN64[WIDTH-1:0];
`endif

    // Overflow detect and, when enabled, the clamp to the signed extreme.
    always_comb begin
        w_ovf = (r_a_msb != r_b_msb) && (w_sum[WIDTH-1] != r_a_msb);
`ifdef SUB_SAT_EN
        if (w_ovf) begin
            w_diff = r_a_msb ? L_SMIN : L_SMAX;
        end else begin
            w_diff = w_sum;
        end
`else
        w_diff = w_sum;
`endif
    end

    // Valid bits and stage-2 result registers; a bubble loads zeros so idle outputs read 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid1 <= 1'b0;
            r_valid2 <= 1'b0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_adv1) begin
                r_valid1 <= in_valid;
            end else begin
                r_valid1 <= r_valid1;
            end
            if (w_adv2) begin
                r_valid2 <= r_valid1;
                if (r_valid1) begin
                    r_diff   <= w_diff;
                    r_borrow <= ~w_c[WIDTH-1];
                    r_ovf    <= w_ovf;
                end else begin
                    r_diff   <= '0;
                    r_borrow <= 1'b0;
                    r_ovf    <= 1'b0;
                end
            end else begin
                r_valid2 <= r_valid2;
            end
        end
    end

endmodule

// File: tb/tb_bk_sub_pipe.sv
// Directed bench for bk_sub_pipe at WIDTH=16: arithmetic vectors, backpressure stream, mid-stream reset.
// Expected saturating results are selected when SUB_SAT_EN is defined.
module tb_bk_sub_pipe;

    localparam int W = 32'sd16;

`ifdef SUB_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         borrow_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         borrow_out;
    logic         ovf;

    int n_vec;
    int n_err;
    int tx;
    int rx;

    logic [W-1:0] sa  [8];
    logic [W-1:0] sb  [8];
    logic         sbi [8];
    logic [W-1:0] se  [8];

    bk_sub_pipe #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .borrow_in  (borrow_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .diff       (diff),
        .borrow_out (borrow_out),
        .ovf        (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single beat with out_ready high: checks exact 2-cycle latency and the result.
    task automatic send(input string tag, input logic [15:0] va, input logic [15:0] vb,
                        input logic vbi, input logic [15:0] ed, input logic ebo, input logic eovf);
        a = va; b = vb; borrow_in = vbi; in_valid = 1'b1;
        #1 chk({tag, "/in_ready"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0; a = 'x; b = 'x; borrow_in = 1'bx;
        #1 chk({tag, "/early_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "/idle_diff"}, 32'(diff), 32'd0);
        tick();
        #1 chk({tag, "/valid"}, 32'(out_valid), 32'd1);
        chk({tag, "/diff"}, 32'(diff), 32'(ed));
        chk({tag, "/borrow"}, 32'(borrow_out), 32'(ebo));
        chk({tag, "/ovf"}, 32'(ovf), 32'(eovf));
        tick();
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; borrow_in = 1'b0;
        #1 chk("rst/out_valid", 32'(out_valid), 32'd0);
        chk("rst/diff", 32'(diff), 32'd0);
        chk("rst/borrow", 32'(borrow_out), 32'd0);
        chk("rst/ovf", 32'(ovf), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1 chk("rst/in_ready", 32'(in_ready), 32'd1);
        tick();

        send("v5m3",     16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0);
        send("v0m1",     16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
        send("veq_bin",  16'h1234, 16'h1234, 1'b1, 16'hFFFF, 1'b1, 1'b0);
        send("vzero_bin",16'h0100, 16'h00FF, 1'b1, 16'h0000, 1'b0, 1'b0);
        send("vneg_ovf", 16'h8000, 16'h0001, 1'b0, SAT ? 16'h8000 : 16'h7FFF, 1'b0, 1'b1);
        send("vpos_ovf", 16'h7FFF, 16'hFFFF, 1'b0, SAT ? 16'h7FFF : 16'h8000, 1'b1, 1'b1);
        send("vmix_ovf", 16'hA5A5, 16'h5A5A, 1'b0, SAT ? 16'h8000 : 16'h4B4B, 1'b0, 1'b1);
        send("vm1m1",    16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0);

        for (int k = 0; k < 8; k++) begin
            sa[k]  = 16'(16'h0110 * k + 16'h0023);
            sb[k]  = 16'(16'h0031 * k);
            sbi[k] = k[0];
            se[k]  = sa[k] - sb[k] - {15'd0, sbi[k]};
        end

        // Eight beats, out_ready low in cycles 3-5, in_valid dropped in cycle 7.
        tx = 0; rx = 0;
        for (int c = 0; c < 40 && rx < 8; c++) begin
            out_ready = !(c >= 3 && c <= 5);
            if (tx < 8 && c != 7) begin
                in_valid = 1'b1; a = sa[tx]; b = sb[tx]; borrow_in = sbi[tx];
            end else begin
                in_valid = 1'b0; a = 'x; b = 'x; borrow_in = 1'bx;
            end
            #1;
            if (c >= 3 && c <= 5) begin
                chk("stall/in_ready", 32'(in_ready), 32'd0);
                chk("stall/out_valid", 32'(out_valid), 32'd1);
                chk("stall/diff", 32'(diff), 32'(se[rx]));
            end
            if (out_valid && out_ready) begin
                chk("stream/diff", 32'(diff), 32'(se[rx]));
                chk("stream/borrow", 32'(borrow_out), 32'd0);
                rx++;
            end
            if (in_valid && in_ready) begin
                tx++;
            end
            tick();
        end
        chk("stream/rx_count", 32'(rx), 32'd8);
        chk("stream/tx_count", 32'(tx), 32'd8);
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        chk("stream/no_extra", 32'(out_valid), 32'd0);

        // Two beats in flight, then an asynchronous reset between clock edges.
        a = 16'h0009; b = 16'h0002; borrow_in = 1'b0; in_valid = 1'b1;
        tick();
        a = 16'h0030; b = 16'h0010;
        tick();
        in_valid = 1'b0;
        #1 chk("inflight/valid", 32'(out_valid), 32'd1);
        chk("inflight/diff", 32'(diff), 32'h0007);
        rst = 1'b1;
        #1 chk("arst/out_valid", 32'(out_valid), 32'd0);
        chk("arst/diff", 32'(diff), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        #1 chk("arst/in_ready", 32'(in_ready), 32'd1);
        chk("arst/still_empty", 32'(out_valid), 32'd0);
        tick();
        chk("arst/dropped", 32'(out_valid), 32'd0);
        send("post_rst", 16'h0003, 16'h0005, 1'b0, 16'hFFFE, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bk_sub_pipe.md
Name: bk_sub_pipe

Overview:
- Pipelined two's-complement subtractor, diff = a - b - borrow_in, for the FIR datapath (coefficient/tap difference terms, symmetric-tap pre-subtraction).
- Complements the 16-bit Brent-Kung prefix adder: same prefix network, run in the subtract direction.
- Two register stages with a valid/ready handshake, so it can sit between FIR stages that apply backpressure.

Parameters:
WIDTH, 16, operand/result width; power of two, 4..64; prefix tree depth = log2(WIDTH).

Ports:
clk  input  1  single clock; all state on rising edge
rst  input  1  reset; asynchronous, active-high
in_valid  input  1  operand beat valid
in_ready  output  1  stage 1 can accept a beat
a  input  WIDTH  minuend
b  input  WIDTH  subtrahend
borrow_in  input  1  borrow into LSB
out_valid  output  1  result beat valid
out_ready  input  1  downstream accepts result
diff  output  WIDTH  a - b - borrow_in, modulo 2^WIDTH (or saturated, see Optional Feature)
borrow_out  output  1  unsigned borrow; 1 when a < b + borrow_in
ovf  output  1  signed overflow of the subtraction

Behaviour:
- Interface: one clock `clk`; reset `rst` is asynchronous and active-high.
- Reset: all valid bits, diff, borrow_out and ovf clear to 0; in_ready = 1 one cycle after reset deasserts.
- Arithmetic form: a + ~b + cin, with cin = ~borrow_in.
  - Bit i: G_i = a_i & ~b_i, P_i = a_i ^ ~b_i.
  - Operator (g,p)o(g',p') = (g | p&g', p&p').
- Stage 1 (registered): P/G for every bit, then the Brent-Kung up-sweep (spans 2, 4, ... WIDTH). Registers: up-sweep group (g,p), raw P, cin, a_msb, b_msb, valid1.
- Stage 2 (registered): down-sweep fills the odd/intermediate prefixes, then the carry ripple from cin through group terms (c_i = g_i | p_i&c_{i-1}), then diff_i = P_i ^ c_{i-1}.
  - borrow_out = ~c_WIDTH.
  - ovf = (a_msb != b_msb) & (diff_msb != a_msb).
- Latency: exactly 2 cycles from accept (in_valid&in_ready) to out_valid when out_ready is held high. Throughput: 1 beat/cycle.
- Handshake:
  - Stage 2 advances when !valid2 | out_ready.
  - Stage 1 advances when !valid1 | stage-2 advance.
  - in_ready = stage-1 advance (combinational from out_ready; no skid buffer).
  - Output signals stay stable while out_valid & !out_ready.
  - in_valid may drop without a transfer; no data is lost or duplicated.
- Boundaries:
  - out_ready low with both stages full: in_ready = 0, contents frozen.
  - Same cycle as out_ready returns: new accept and output retire both occur, no bubble.
  - borrow_in = 1 with a == b: diff all ones, borrow_out = 1.
  - rst asserted mid-stream: in-flight beats discarded, outputs cleared immediately (async).
- Data registers are not reset-gated beyond the above; X on a/b while in_valid = 0 must not propagate to diff when out_valid = 0 (outputs gated to 0).

Optional Feature:
- Macro: SUB_SAT_EN.
- Defined: when ovf = 1, diff is clamped to the signed extreme. a_msb = 0 gives 0111..1; a_msb = 1 gives 1000..0. ovf still reports 1; borrow_out is unchanged. The clamp mux is in stage 2, so latency stays 2.
- Undefined: diff wraps modulo 2^WIDTH; no clamp logic is synthesised.

Decomposition:
- Package fir_arith_pkg:
  - localparam-style function clog2 for tree depth.
  - typedef pg_t {g, p} shared with the adder family.
  - Constants for the signed max/min of WIDTH.
- Sub-module bk_pg_cell: one combinational (g,p) prefix operator, instanced in both sweeps. No other sub-modules.

Test Plan:
- a=0x0005, b=0x0003, borrow_in=0, out_ready=1 -> 2 cycles later diff=0x0002, borrow_out=0, ovf=0.
- a=0x0000, b=0x0001, borrow_in=0 -> diff=0xFFFF, borrow_out=1, ovf=0; then a=0x1234, b=0x1234, borrow_in=1 -> diff=0xFFFF, borrow_out=1.
- a=0x8000, b=0x0001 -> ovf=1; diff=0x7FFF without SUB_SAT_EN, 0x8000 with it. a=0x7FFF, b=0xFFFF -> ovf=1; diff=0x8000 / 0x7FFF respectively.
- Stream 8 back-to-back beats, out_ready low for cycles 3-5 -> in_ready low while both stages are full, diff stable, all 8 results in order, none dropped or duplicated.
- Random 10k beats with random in_valid/out_ready against a reference model (a-b-borrow_in mod 2^16) -> zero mismatches; repeat at WIDTH=32.
- Assert rst for 1 cycle with 2 beats in flight -> out_valid=0, diff=0 immediately; in_ready=1 next cycle; next accepted beat appears 2 cycles after accept.
